// File: rtl/counter_mem_pkg.sv
// Shared sizes, master IDs and response-pipe entry layout for the on-chip RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_mem_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MEM_DEPTH = 10024;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  // One slot of the read-response shift register
  typedef struct packed {
    logic vld;  // an accepted read occupies this slot
    logic id;   // master that issued it
    logic oor;  // address was out of range: return zero instead of RAM data
  } rsp_t;

endpackage

// File: rtl/counter_rr_arb2.sv
// Two-way round-robin arbiter: the master that did not win last time wins a tie.
// Latency: grant is combinational from req; last_grant updates on the clock after a granted cycle.
// Backpressure: a losing requester simply sees no grant and must hold its request.
module counter_rr_arb2
  import counter_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  // Single requester wins outright; on a tie the master not in last_grant wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == ID_M1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner of each granted cycle; reset favours m0 on the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= ID_M1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/counter_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters, one access per cycle.
// Latency: zero added on the request path; read data returns READ_LATENCY cycles after acceptance.
// Backpressure: per-master waitrequest, low only in the cycle that master is granted.
module counter_onchip_mem_arbiter #(
  parameter int ADDR_W       = counter_mem_pkg::ADDR_W,
  parameter int DATA_W       = counter_mem_pkg::DATA_W,
  parameter int MEM_DEPTH    = counter_mem_pkg::MEM_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  err_oor,
  output logic                  err_rw
);

  import counter_mem_pkg::rsp_t;
  import counter_mem_pkg::ID_M0;
  import counter_mem_pkg::ID_M1;

  localparam int BE_W = DATA_W / 8;

  logic              ready;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              last_grant;
  logic              acc;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_rd;
  logic              sel_wr;
  logic              is_rd;
  logic              oor;
  rsp_t              rsp_pipe [READ_LATENCY];
  rsp_t              rsp_out;

  // Hold off all masters until the first clock after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  assign req = {ready & (m1_read | m1_write), ready & (m0_read | m0_write)};

  counter_rr_arb2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .advance    (acc),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign acc = |grant;
  // Idle cycles park the select on the last winner so it does not toggle needlessly
  assign sel = acc ? grant[1] : last_grant;

  assign m0_waitrequest = ~ready | ~grant[0];
  assign m1_waitrequest = ~ready | ~grant[1];

  // Request mux: pick the granted master's command
  always_comb begin
    sel_addr  = m0_address;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    sel_rd    = m0_read;
    sel_wr    = m0_write;
    if (sel == ID_M1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_rd    = m1_read;
      sel_wr    = m1_write;
    end
  end

  // read+write together behaves as a write
  assign is_rd = sel_rd & ~sel_wr;
  assign oor   = 32'(sel_addr) >= 32'(MEM_DEPTH);

  assign mem_address    = acc ? sel_addr  : '0;
  assign mem_byteenable = acc ? sel_be    : '0;
  assign mem_writedata  = acc ? sel_wdata : '0;
  assign mem_chipselect = acc & ~oor;
  assign mem_write      = acc & ~oor & sel_wr;
  assign mem_clken      = ready;

  // Fixed-latency response shift register; reset discards reads in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rsp_pipe[i] <= '0;
      end
    end else begin
      rsp_pipe[0] <= '{vld: acc & is_rd, id: sel, oor: oor};
      for (int i = 1; i < READ_LATENCY; i++) begin
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign rsp_out = rsp_pipe[READ_LATENCY-1];

  assign m0_readdatavalid = rsp_out.vld & (rsp_out.id == ID_M0);
  assign m1_readdatavalid = rsp_out.vld & (rsp_out.id == ID_M1);
  assign m0_readdata      = (m0_readdatavalid && !rsp_out.oor) ? mem_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid && !rsp_out.oor) ? mem_readdata : '0;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_oor <= 1'b0;
      err_rw  <= 1'b0;
    end else begin
      err_oor <= err_oor | (acc & oor);
      err_rw  <= err_rw | (acc & sel_rd & sel_wr);
    end
  end

endmodule
